// File: rtl/tcp_rx_parse_pkg.sv
// Shared types and constants for the TCP receive header parser and its checksum unit.
package tcp_rx_parse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPT,
        PLD,
        DROP
    } state_t;

    localparam int         TCP_HDR_BYTES = 20;
    localparam logic [7:0] TCP_PROTO     = 8'h06;

    // Bit positions inside the 8-bit flags byte {cwr,ece,urg,ack,psh,rst,syn,fin}
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;
    localparam int FLAG_ECE = 6;
    localparam int FLAG_CWR = 7;

    // Fixed TCP header in wire order, so 20 bytes shifted in MSB-first land in place
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  offset;
        logic [3:0]  rsvd;
        logic [7:0]  flags;
        logic [15:0] wnd;
        logic [15:0] chk;
        logic [15:0] urg_ptr;
    } tcp_hdr_t;

    // End-around carry fold of a 20-bit one's-complement sum down to 16 bits.
    // Two passes suffice: the first leaves at most 0x1000E.
    function automatic logic [15:0] csum_fold(input logic [19:0] a);
        logic [16:0] t;
        t = {1'b0, a[15:0]} + {13'd0, a[19:16]};
        return t[15:0] + {15'd0, t[16]};
    endfunction

endpackage

// File: rtl/tcp_rx_csum.sv
// Byte-serial one's-complement accumulator with clear/add controls and folded outputs.
import tcp_rx_parse_pkg::*;

module tcp_rx_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic        hi,
    input  logic [7:0]  dat,
    output logic [15:0] sum_now,
    output logic [15:0] sum_nxt
);

    logic [19:0] acc_q, acc_d;
    logic [15:0] word;

    // Place the byte in the high or low half of its 16-bit word and accumulate;
    // the running value is pre-folded so long segments never overflow 20 bits.
    always_comb begin
        word  = hi ? {dat, 8'h00} : {8'h00, dat};
        acc_d = acc_q;
        if (clr) begin
            acc_d = add ? {4'h0, word} : 20'h0;
        end else if (add) begin
            acc_d = {4'h0, csum_fold(acc_q)} + {4'h0, word};
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= 20'h0;
        else        acc_q <= acc_d;
    end

    assign sum_now = csum_fold(acc_q);
    assign sum_nxt = csum_fold(acc_d);

endmodule

// File: rtl/tcp_rx_hdr_parser.sv
// TCP receive header parser: captures the fixed header, skips options, forwards
// payload with one cycle of latency, and checks segment length and checksum.
import tcp_rx_parse_pkg::*;

module tcp_rx_hdr_parser #(
    parameter bit VERIFY_CHK    = 1'b1,
    parameter int MAX_OPT_BYTES = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_dat,
    input  logic        in_val,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic        in_err,
    input  logic [31:0] in_src_ip,
    input  logic [31:0] in_dst_ip,
    input  logic [15:0] in_tcp_len,
    output logic [15:0] hdr_src_port,
    output logic [15:0] hdr_dst_port,
    output logic [31:0] hdr_seq_num,
    output logic [31:0] hdr_ack_num,
    output logic [3:0]  hdr_offset,
    output logic [7:0]  hdr_flags,
    output logic [15:0] hdr_wnd,
    output logic [15:0] hdr_chk,
    output logic [15:0] hdr_urg_ptr,
    output logic        meta_val,
    output logic [7:0]  out_dat,
    output logic        out_val,
    output logic        out_sof,
    output logic        out_eof,
    output logic        done,
    output logic        chk_ok,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  opt_cnt_q, opt_cnt_d;
    tcp_hdr_t    sh_q, sh_d;      // header being assembled
    tcp_hdr_t    hdr_q, hdr_d;    // header presented downstream
    logic        meta_val_q, meta_val_d;
    logic        meta_seen_q, meta_seen_d;
    logic        first_pld_q, first_pld_d;
    logic [7:0]  out_dat_q, out_dat_d;
    logic        out_val_q, out_val_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        chk_ok_q, chk_ok_d;
    logic [7:0]  opt_bytes;

    logic        cs_clr, cs_add, cs_hi;
    logic [15:0] sum_now, sum_nxt;
    logic [19:0] pseudo_sum;
    logic [15:0] pseudo_fold;
    logic        verdict_now, verdict_nxt;

    tcp_rx_csum u_csum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cs_clr),
        .add     (cs_add),
        .hi      (cs_hi),
        .dat     (in_dat),
        .sum_now (sum_now),
        .sum_nxt (sum_nxt)
    );

    // Pseudo-header is combinational: the IP fields are stable for the whole segment
    assign pseudo_sum = {4'h0, in_src_ip[31:16]} + {4'h0, in_src_ip[15:0]}
                      + {4'h0, in_dst_ip[31:16]} + {4'h0, in_dst_ip[15:0]}
                      + {12'h0, TCP_PROTO}       + {4'h0, in_tcp_len};
    assign pseudo_fold = csum_fold(pseudo_sum);
    assign verdict_now = !VERIFY_CHK || (csum_fold({4'h0, sum_now} + {4'h0, pseudo_fold}) == 16'hFFFF);
    assign verdict_nxt = !VERIFY_CHK || (csum_fold({4'h0, sum_nxt} + {4'h0, pseudo_fold}) == 16'hFFFF);

    // Parser FSM: next state, header capture, payload forwarding, segment verdict
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        opt_cnt_d   = opt_cnt_q;
        sh_d        = sh_q;
        hdr_d       = hdr_q;
        meta_seen_d = meta_seen_q;
        first_pld_d = first_pld_q;
        out_dat_d   = out_dat_q;
        meta_val_d  = 1'b0;
        out_val_d   = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        chk_ok_d    = 1'b0;
        cs_clr      = 1'b0;
        cs_add      = 1'b0;
        cs_hi       = 1'b1;
        opt_bytes   = 8'h00;

        if (in_val && in_sof) begin
            // A new segment always wins; an unfinished one is closed as an error
            if (state_q != IDLE) begin
                done_d   = 1'b1;
                err_d    = 1'b1;
                chk_ok_d = verdict_now;
            end
            state_d     = HDR;
            byte_cnt_d  = 16'd1;
            sh_d        = tcp_hdr_t'({sh_q[151:0], in_dat});
            meta_seen_d = 1'b0;
            first_pld_d = 1'b1;
            cs_clr      = 1'b1;
            cs_add      = 1'b1;
            if (in_eof) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                err_d    = 1'b1;
                chk_ok_d = verdict_nxt;
            end
        end else if (in_val && state_q != IDLE) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            cs_add     = 1'b1;
            cs_hi      = ~byte_cnt_q[0];
            case (state_q)
                HDR: begin
                    sh_d = tcp_hdr_t'({sh_q[151:0], in_dat});
                    if (byte_cnt_q == 16'(TCP_HDR_BYTES - 1)) begin
                        opt_bytes = {2'b00, sh_d.offset, 2'b00} - 8'd20;
                        if (sh_d.offset < 4'd5 || int'(opt_bytes) > MAX_OPT_BYTES) begin
                            state_d = DROP;
                        end else if (sh_d.offset == 4'd5) begin
                            state_d     = PLD;
                            meta_val_d  = 1'b1;
                            meta_seen_d = 1'b1;
                            hdr_d       = sh_d;
                        end else begin
                            state_d   = OPT;
                            opt_cnt_d = opt_bytes;
                        end
                    end
                end
                OPT: begin
                    opt_cnt_d = opt_cnt_q - 8'd1;
                    if (opt_cnt_q == 8'd1) begin
                        state_d     = PLD;
                        meta_val_d  = 1'b1;
                        meta_seen_d = 1'b1;
                        hdr_d       = sh_q;
                    end
                end
                PLD: begin
                    out_val_d   = 1'b1;
                    out_dat_d   = in_dat;
                    out_sof_d   = first_pld_q;
                    out_eof_d   = in_eof;
                    first_pld_d = 1'b0;
                end
                default: ;
            endcase
            if (in_eof) begin
                done_d   = 1'b1;
                err_d    = !meta_seen_d || (state_d == DROP) || in_err
                         || (byte_cnt_d != in_tcp_len);
                chk_ok_d = verdict_nxt;
                state_d  = IDLE;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 16'h0;
            opt_cnt_q   <= 8'h0;
            sh_q        <= '0;
            hdr_q       <= '0;
            meta_val_q  <= 1'b0;
            meta_seen_q <= 1'b0;
            first_pld_q <= 1'b0;
            out_dat_q   <= 8'h0;
            out_val_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            chk_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            opt_cnt_q   <= opt_cnt_d;
            sh_q        <= sh_d;
            hdr_q       <= hdr_d;
            meta_val_q  <= meta_val_d;
            meta_seen_q <= meta_seen_d;
            first_pld_q <= first_pld_d;
            out_dat_q   <= out_dat_d;
            out_val_q   <= out_val_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            done_q      <= done_d;
            err_q       <= err_d;
            chk_ok_q    <= chk_ok_d;
        end
    end

    assign hdr_src_port = hdr_q.src_port;
    assign hdr_dst_port = hdr_q.dst_port;
    assign hdr_seq_num  = hdr_q.seq_num;
    assign hdr_ack_num  = hdr_q.ack_num;
    assign hdr_offset   = hdr_q.offset;
    assign hdr_flags    = hdr_q.flags;
    assign hdr_wnd      = hdr_q.wnd;
    assign hdr_chk      = hdr_q.chk;
    assign hdr_urg_ptr  = hdr_q.urg_ptr;
    assign meta_val     = meta_val_q;
    assign out_dat      = out_dat_q;
    assign out_val      = out_val_q;
    assign out_sof      = out_sof_q;
    assign out_eof      = out_eof_q;
    assign done         = done_q;
    assign err          = err_q;
    assign chk_ok       = chk_ok_q;

endmodule
